ws_bus_initiator: RTL and testbench

Synthesizable WonderSwan cartridge-bus initiator: it performs single memory or IO read/write cycles toward a cartridge (the nileswan FPGA) from a simple command/response interface. It drives the cartridge-side strobes, address, data and SClk exactly as the console does. It is the console end of the cart bus, used by the hardware test rig and the system-level bench to exercise bank registers, SPI control, bootrom and PSRAM/SRAM mapping.

---
 rtl/nileswan_bus_pkg.sv | 43 ++++
 rtl/ws_sclk_gen.sv | 31 +++
 rtl/ws_bus_initiator.sv | 184 ++++++++++++++++++
 tb/tb_ws_bus_initiator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nileswan_bus_pkg.sv
// Shared cart-bus definitions: IO port numbers seen on the WonderSwan
// cartridge bus, the initiator state encoding, and the IO-port-to-address
// mapping the console uses when it runs an IO cycle.
package nileswan_bus_pkg;

    // Console bank registers
    localparam logic [7:0] IO_BANK_LINEAR  = 8'hC0;
    localparam logic [7:0] IO_BANK_RAM     = 8'hC1;
    localparam logic [7:0] IO_BANK_ROM0    = 8'hC2;
    localparam logic [7:0] IO_BANK_ROM1    = 8'hC3;
    localparam logic [7:0] IO_MEMORY_CTRL  = 8'hCE;

    // Extended (16-bit) bank registers
    localparam logic [7:0] IO_BANK_RAM_LO  = 8'hD0;
    localparam logic [7:0] IO_BANK_RAM_HI  = 8'hD1;
    localparam logic [7:0] IO_BANK_ROM0_LO = 8'hD2;
    localparam logic [7:0] IO_BANK_ROM0_HI = 8'hD3;
    localparam logic [7:0] IO_BANK_ROM1_LO = 8'hD4;
    localparam logic [7:0] IO_BANK_ROM1_HI = 8'hD5;

    // nileswan-specific registers (SPI control, bootrom, mapping)
    localparam logic [7:0] IO_NILE_REG0    = 8'hE0;
    localparam logic [7:0] IO_NILE_REG1    = 8'hE1;
    localparam logic [7:0] IO_NILE_REG2    = 8'hE2;
    localparam logic [7:0] IO_NILE_REG3    = 8'hE3;
    localparam logic [7:0] IO_NILE_REG4    = 8'hE4;
    localparam logic [7:0] IO_NILE_REG5    = 8'hE5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } ws_bus_state_t;

    // The console places the port's high nibble on AddrHi and the low
    // nibble on the bottom of AddrLo; every other address line is low.
    function automatic logic [19:0] io_port_to_addr(input logic [7:0] port);
        return {port[7:4], 12'h000, port[3:0]};
    endfunction

endpackage

// File: rtl/ws_sclk_gen.sv
// Free-running cartridge serial clock: toggles every SCLK_DIV FastClk
// cycles, starting low out of reset, unaffected by bus transactions.
module ws_sclk_gen #(
    parameter int SCLK_DIV = 32
) (
    input  logic FastClk,
    input  logic Reset,
    output logic SClk
);

    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

    logic [7:0] r_div;
    logic       r_sclk;

    // Half-period counter; SClk flips when the counter wraps
    always_ff @(posedge FastClk) begin
        if (Reset) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    assign SClk = r_sclk;

endmodule

// File: rtl/ws_bus_initiator.sv
// Console-side WonderSwan cartridge bus initiator. Runs one memory or IO
// read/write cycle per accepted command with programmable setup, strobe
// and hold lengths, then presents a response. All bus outputs are
// registered so the strobes are glitch-free at the cartridge pins.
module ws_bus_initiator
    import nileswan_bus_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int SCLK_DIV      = 32
) (
    input  logic        FastClk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_io,
    input  logic        cmd_word,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        nSel,
    output logic        nOE,
    output logic        nWE,
    output logic        nIO,
    output logic [19:0] Addr,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [15:0] data_in,
    output logic        SClk
);

    // Phase counter reload values: the counter runs N-1 down to 0, so a
    // phase of length 1 leaves on the first edge after entry.
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    ws_bus_state_t r_state;
    logic [7:0]    r_phase;
    logic          r_write;
    logic          r_word;
    logic          r_io;
    logic          r_cmd_ready;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_rdata;
    logic          r_nsel;
    logic          r_noe;
    logic          r_nwe;
    logic          r_nio;
    logic [19:0]   r_addr;
    logic [15:0]   r_data_out;
    logic          r_data_oe;
    logic          w_sclk;

    // Writes report zero; IO reads and byte reads only carry the low lane.
    function automatic logic [15:0] read_lane(input logic        wr,
                                              input logic        io,
                                              input logic        word,
                                              input logic [15:0] din);
        if (wr)
            return 16'h0000;
        else if (word && !io)
            return din;
        else
            return {8'h00, din[7:0]};
    endfunction

    // Bus cycle sequencer with registered strobes, address and data
    always_ff @(posedge FastClk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_write     <= 1'b0;
            r_word      <= 1'b0;
            r_io        <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_nsel      <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_nio       <= 1'b1;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_data_oe   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= ST_SETUP;
                        r_phase     <= SETUP_LAST;
                        r_write     <= cmd_write;
                        r_word      <= cmd_word;
                        r_io        <= cmd_io;
                        r_cmd_ready <= 1'b0;
                        r_nsel      <= 1'b0;
                        r_nio       <= ~cmd_io;
                        r_addr      <= cmd_io ? io_port_to_addr(cmd_addr[7:0])
                                              : cmd_addr;
                        if (cmd_write) begin
                            r_data_oe  <= 1'b1;
                            r_data_out <= cmd_wdata;
                        end
                    end
                end

                ST_SETUP: begin
                    if (r_phase == 8'd0) begin
                        r_state <= ST_STROBE;
                        r_phase <= STROBE_LAST;
                        r_noe   <= r_write;
                        r_nwe   <= ~r_write;
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end

                ST_STROBE: begin
                    if (r_phase == 8'd0) begin
                        // Read data is sampled while nOE is still low
                        r_state     <= ST_HOLD;
                        r_phase     <= HOLD_LAST;
                        r_noe       <= 1'b1;
                        r_nwe       <= 1'b1;
                        r_rsp_rdata <= read_lane(r_write, r_io, r_word, data_in);
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (r_phase == 8'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_nsel      <= 1'b1;
                        r_nio       <= 1'b1;
                        r_addr      <= '0;
                        r_data_oe   <= 1'b0;
                        r_data_out  <= '0;
                    end else begin
                        r_phase <= r_phase - 8'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ws_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .FastClk (FastClk),
        .Reset   (Reset),
        .SClk    (w_sclk)
    );

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign nSel      = r_nsel;
    assign nOE       = r_noe;
    assign nWE       = r_nwe;
    assign nIO       = r_nio;
    assign Addr      = r_addr;
    assign data_out  = r_data_out;
    assign data_oe   = r_data_oe;
    assign SClk      = w_sclk;

endmodule

// File: tb/tb_ws_bus_initiator.sv
// Directed bench for ws_bus_initiator (default phase lengths, SCLK_DIV=3).
// Offsets n are counted in rising edges after the accept edge (n=0) and
// sampled 1 time unit after that edge.
module tb_ws_bus_initiator;

    logic        FastClk;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_io;
    logic        cmd_word;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        nSel;
    logic        nOE;
    logic        nWE;
    logic        nIO;
    logic [19:0] Addr;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        SClk;

    int n_vec  = 0;
    int n_miss = 0;
    int viol   = 0;

    // Per-transaction observations filled by run_txn
    int          t_first_we, t_cnt_we, t_first_oe, t_cnt_oe, t_rsp_at;
    logic [15:0] t_rdata;
    logic [19:0] t_addr;
    logic        t_nio, t_doe, t_oe_any;
    logic [15:0] t_dout;

    ws_bus_initiator #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (4),
        .HOLD_CYCLES   (1),
        .SCLK_DIV      (3)
    ) dut (
        .FastClk   (FastClk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_io    (cmd_io),
        .cmd_word  (cmd_word),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .nSel      (nSel),
        .nOE       (nOE),
        .nWE       (nWE),
        .nIO       (nIO),
        .Addr      (Addr),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .data_in   (data_in),
        .SClk      (SClk)
    );

    initial FastClk = 1'b0;
    always #5 FastClk = ~FastClk;

    // Bus-protocol watchdog on every cycle
    always @(negedge FastClk) begin
        if ((!nOE && !nWE) || (!nOE && nSel) || (!nWE && nSel) ||
            (data_oe && !nOE) || (data_oe && nSel))
            viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge FastClk);
        #1;
    endtask

    task automatic run_txn(input logic wr, input logic io, input logic word,
                           input logic [19:0] a, input logic [15:0] wd,
                           input logic [15:0] din);
        cmd_write  = wr;
        cmd_io     = io;
        cmd_word   = word;
        cmd_addr   = a;
        cmd_wdata  = wd;
        data_in    = din;
        rsp_ready  = 1'b1;
        cmd_valid  = 1'b1;
        t_first_we = -1; t_cnt_we = 0;
        t_first_oe = -1; t_cnt_oe = 0;
        t_rsp_at   = -1; t_rdata  = 16'hDEAD;
        t_oe_any   = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (n == 0) begin
                cmd_valid = 1'b0;
                t_addr    = Addr;
                t_nio     = nIO;
                t_dout    = data_out;
                t_doe     = data_oe;
            end
            if (data_oe) t_oe_any = 1'b1;
            if (!nWE) begin
                if (t_first_we < 0) t_first_we = n;
                t_cnt_we++;
            end
            if (!nOE) begin
                if (t_first_oe < 0) t_first_oe = n;
                t_cnt_oe++;
            end
            if (rsp_valid) begin
                t_rsp_at = n;
                t_rdata  = rsp_rdata;
                break;
            end
        end
        tick();
    endtask

    initial begin
        int b_vld, b_data, b_rdy, b_sel, got_at, rsp_seen;
        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_io    = 1'b0;
        cmd_word  = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        data_in   = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_strobes", 32'({nSel, nOE, nWE, nIO}), 32'hF);
        chk("rst_addr", 32'(Addr), 32'h0);
        chk("rst_data", 32'({data_oe, data_out}), 32'h0);
        chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'h0);
        chk("rst_ready_sclk", 32'({cmd_ready, SClk}), 32'h2);

        // SClk: first rise 3 edges after release, period 6
        Reset = 1'b0;
        tick(); tick();
        chk("sclk_before_rise", 32'(SClk), 32'h0);
        tick();
        chk("sclk_first_rise", 32'(SClk), 32'h1);
        tick(); tick();
        chk("sclk_high_hold", 32'(SClk), 32'h1);
        tick();
        chk("sclk_fall", 32'(SClk), 32'h0);
        repeat (3) tick();
        chk("sclk_period", 32'(SClk), 32'h1);

        // IO write 0x05 to port 0xC2
        run_txn(1'b1, 1'b1, 1'b0, 20'h000C2, 16'h0005, 16'hFFFF);
        chk("iow_addr", 32'(t_addr), 32'h000C0002);
        chk("iow_nio", 32'(t_nio), 32'h0);
        chk("iow_dout", 32'(t_dout), 32'h0005);
        chk("iow_doe", 32'(t_doe), 32'h1);
        chk("iow_we_first", t_first_we, 2);
        chk("iow_we_len", t_cnt_we, 4);
        chk("iow_no_oe", t_cnt_oe, 0);
        chk("iow_rsp_at", t_rsp_at, 7);
        chk("iow_rdata", 32'(t_rdata), 32'h0);

        // 16-bit memory read at 0x20010
        run_txn(1'b0, 1'b0, 1'b1, 20'h20010, 16'h0000, 16'hBEEF);
        chk("mrw_addr", 32'(t_addr), 32'h00020010);
        chk("mrw_nio", 32'(t_nio), 32'h1);
        chk("mrw_doe", 32'(t_oe_any), 32'h0);
        chk("mrw_oe_first", t_first_oe, 2);
        chk("mrw_oe_len", t_cnt_oe, 4);
        chk("mrw_no_we", t_cnt_we, 0);
        chk("mrw_rsp_at", t_rsp_at, 7);
        chk("mrw_rdata", 32'(t_rdata), 32'hBEEF);

        // Byte memory read keeps only the low lane
        run_txn(1'b0, 1'b0, 1'b0, 20'h00345, 16'h0000, 16'h12AB);
        chk("mrb_addr", 32'(t_addr), 32'h00000345);
        chk("mrb_rdata", 32'(t_rdata), 32'h00AB);

        // IO read of port 0xE2 with word set and junk upper address bits
        run_txn(1'b0, 1'b1, 1'b1, 20'hFF3E2, 16'h0000, 16'h5566);
        chk("ior_addr", 32'(t_addr), 32'h000E0002);
        chk("ior_nio", 32'(t_nio), 32'h0);
        chk("ior_doe", 32'(t_oe_any), 32'h0);
        chk("ior_rdata", 32'(t_rdata), 32'h0066);

        // Response back-pressure with a second command waiting
        cmd_write = 1'b0; cmd_io = 1'b0; cmd_word = 1'b1;
        cmd_addr  = 20'h12345; data_in = 16'hCAFE;
        rsp_ready = 1'b0; cmd_valid = 1'b1;
        got_at = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rsp_valid) begin
                got_at = n;
                break;
            end
        end
        chk("bp_rsp_at", got_at, 7);
        chk("bp_rdata", 32'(rsp_rdata), 32'hCAFE);
        data_in = 16'h0000;
        b_vld = 0; b_data = 0; b_rdy = 0; b_sel = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (!rsp_valid) b_vld++;
            if (rsp_rdata !== 16'hCAFE) b_data++;
            if (cmd_ready) b_rdy++;
            if (!nSel) b_sel++;
        end
        chk("bp_valid_stable", b_vld, 0);
        chk("bp_rdata_stable", b_data, 0);
        chk("bp_ready_low", b_rdy, 0);
        chk("bp_no_sel", b_sel, 0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_cycle", 32'({cmd_ready, nSel, rsp_valid}), 32'h6);
        tick();
        chk("bp_next_accept", 32'({cmd_ready, nSel}), 32'h0);
        cmd_valid = 1'b0;
        got_at = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rsp_valid) begin
                got_at = n;
                break;
            end
        end
        chk("bp_second_rsp_at", got_at, 6);
        chk("bp_second_rdata", 32'(rsp_rdata), 32'h0000);
        tick();

        // Reset in the middle of a write strobe
        cmd_write = 1'b1; cmd_io = 1'b0; cmd_word = 1'b1;
        cmd_addr  = 20'h00100; cmd_wdata = 16'hA55A;
        rsp_ready = 1'b1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_in_strobe", 32'({nWE, nSel, data_oe}), 32'h1);
        Reset = 1'b1;
        tick();
        chk("mid_rst_strobes", 32'({nSel, nOE, nWE, nIO}), 32'hF);
        chk("mid_rst_bus", 32'({data_oe, Addr}), 32'h0);
        chk("mid_rst_ctl", 32'({cmd_ready, rsp_valid}), 32'h2);
        Reset = 1'b0;
        rsp_seen = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (rsp_valid) rsp_seen++;
        end
        chk("mid_rst_no_rsp", rsp_seen, 0);

        chk("strobe_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
